// File: rtl/aes_pkg.sv
// Shared AES constants, block type, sequencer state encoding and GF(2^8) helpers.
package aes_pkg;

    localparam int AES_BLK_W = 128;
    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    typedef logic [AES_BLK_W-1:0] aes_blk_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (0 maps to 0), then the FIPS-197 affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x3, x7, x15, x31, x63, x127, inv;
        x3   = gf_mul(gf_mul(a, a), a);
        x7   = gf_mul(gf_mul(x3, x3), a);
        x15  = gf_mul(gf_mul(x7, x7), a);
        x31  = gf_mul(gf_mul(x15, x15), a);
        x63  = gf_mul(gf_mul(x31, x31), a);
        x127 = gf_mul(gf_mul(x63, x63), a);
        inv  = gf_mul(x127, x127);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns (bypassed
// when last is set) and AddRoundKey. Byte 0 of a block sits at [127:120], column-major.
module aes_enc_round
    import aes_pkg::*;
(
    input  aes_blk_t st,
    input  aes_blk_t rk,
    input  logic     last,
    output aes_blk_t nxt
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];
    aes_blk_t   mixed;

    always_comb begin
        mixed = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            sb[4'(i)] = sbox(st[7'(127 - 8 * i) -: 8]);
        end
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                sr[4'(4 * c + r)] = sb[4'(4 * ((c + r) % 4) + r)];
            end
        end
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                mc[4'(4 * c + r)] = xtime(sr[4'(4 * c + r)]) ^
                                    xtime(sr[4'(4 * c + (r + 1) % 4)]) ^
                                    sr[4'(4 * c + (r + 1) % 4)] ^
                                    sr[4'(4 * c + (r + 2) % 4)] ^
                                    sr[4'(4 * c + (r + 3) % 4)];
            end
        end
        for (int unsigned i = 0; i < 16; i++) begin
            mixed[7'(127 - 8 * i) -: 8] = last ? sr[4'(i)] : mc[4'(i)];
        end
        nxt = mixed ^ rk;
    end

endmodule

// File: rtl/aes_round_seq.sv
// Iterative AES encryption round sequencer sharing one round datapath over NR rounds.
// Optional abort input enabled by defining AES_ROUND_SEQ_ABORT_EN.
module aes_round_seq
    import aes_pkg::*;
#(
    parameter int NR     = NR_AES256,
    parameter int KIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst,
`ifdef AES_ROUND_SEQ_ABORT_EN
    input  logic              abort,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_data,
    output logic [KIDX_W-1:0] rk_idx,
    input  logic [127:0]      rk_data,
    input  logic              rk_valid,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      out_data,
    output logic              busy
);

    if (!(NR == NR_AES128 || NR == NR_AES192 || NR == NR_AES256) || NR >= (1 << KIDX_W)) begin : g_bad_cfg
        $error("aes_round_seq: NR must be 10, 12 or 14 and representable in KIDX_W bits");
    end

    localparam logic [KIDX_W-1:0] LAST_RND = KIDX_W'(NR);

    seq_state_t        state;
    logic [KIDX_W-1:0] rnd;
    aes_blk_t          st;
    aes_blk_t          round_out;
    logic              accept;

    aes_enc_round u_round (
        .st  (st),
        .rk  (rk_data),
        .last(rnd == LAST_RND),
        .nxt (round_out)
    );

    // rnd is parked at 0 outside RUN, so it doubles as the key index for acceptance.
    assign in_ready = !rst && rk_valid && (state == IDLE || (state == DONE && out_ready));
    assign accept   = in_valid && in_ready;
    assign rk_idx   = rnd;
    assign out_data = st;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rnd       <= '0;
            st        <= '0;
            out_valid <= 1'b0;
        end else begin
`ifdef AES_ROUND_SEQ_ABORT_EN
            if (abort && state != IDLE) begin
                state     <= IDLE;
                rnd       <= '0;
                st        <= '0;
                out_valid <= 1'b0;
            end else
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        st    <= in_data ^ rk_data;
                        rnd   <= KIDX_W'(1);
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (rk_valid) begin
                        st <= round_out;
                        if (rnd == LAST_RND) begin
                            rnd       <= '0;
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            rnd <= rnd + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (accept) begin
                            st    <= in_data ^ rk_data;
                            rnd   <= KIDX_W'(1);
                            state <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    rnd       <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_seq.sv
// Self-checking bench for aes_round_seq against a byte-level AES-256 reference model.
module tb_aes_round_seq;

    localparam int NR = 14;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         rk_valid;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
`ifdef AES_ROUND_SEQ_ABORT_EN
    logic         abort = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]   sbox_t [256];
    logic [127:0] keys   [16];
    logic [127:0] junk;

    aes_round_seq #(.NR(NR), .KIDX_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef AES_ROUND_SEQ_ABORT_EN
        .abort    (abort),
`endif
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .rk_idx   (rk_idx),
        .rk_data  (rk_data),
        .rk_valid (rk_valid),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Key store: combinational lookup, garbage whenever it is not valid.
    always_comb rk_data = rk_valid ? keys[rk_idx] : junk;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] mul2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Walk the field with generator 3 and its inverse 0xf6 in lockstep.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ mul2(p);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic expand_key(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t    = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = mul2(rcon);
            end else if (i % 8 == 4) begin
                t = subword(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r <= 14; r++) keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        keys[15] = '0;
    endtask

    function automatic logic [127:0] model_enc(input logic [127:0] pt);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ keys[0][127 - 8 * i -: 8];
        for (int r = 1; r <= NR; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) t[4*c + w] = s[4*((c + w) % 4) + w];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    if (r != NR)
                        s[4*c + w] = mul2(t[4*c + w]) ^ mul2(t[4*c + (w+1)%4]) ^ t[4*c + (w+1)%4]
                                     ^ t[4*c + (w+2)%4] ^ t[4*c + (w+3)%4];
                    else
                        s[4*c + w] = t[4*c + w];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ keys[r][127 - 8 * i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- stimulus helpers (called right after a falling edge) ----------------
    task automatic accept(input logic [127:0] pt, input string tag);
        in_data  = pt;
        in_valid = 1'b1;
        rk_valid = 1'b1;
        #1 chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = rnd128();
    endtask

    task automatic run_to_done(input logic [127:0] exp, input int stall_rnd, input int stall_len,
                               input string tag);
        int   e      = 0;
        int   stalls = 0;
        int   left   = stall_len;
        logic seen   = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
            end else begin
                chk({tag, "_rk_idx"}, 128'(rk_idx), 128'(1 + e - stalls));
                chk({tag, "_busy"}, 128'(busy), 128'(1));
                in_valid  = 1'($urandom % 2);
                in_data   = rnd128();
                out_ready = 1'($urandom % 2);
                if (1 + e - stalls == stall_rnd && left > 0) begin
                    rk_valid = 1'b0;
                    junk     = rnd128();
                    left--;
                    stalls++;
                end else begin
                    rk_valid = 1'b1;
                end
                #1 chk({tag, "_in_ready_run"}, 128'(in_ready), 128'(0));
                @(posedge clk);
                e++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rk_valid  = 1'b1;
        chk({tag, "_done_seen"}, 128'(seen), 128'(1));
        chk({tag, "_latency"}, 128'(e), 128'(NR + stall_len));
        chk({tag, "_out_data"}, out_data, exp);
        chk({tag, "_rk_idx_done"}, 128'(rk_idx), 128'(0));
    endtask

    task automatic drain(input logic [127:0] exp, input int hold, input string tag);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = rnd128();
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_hold_valid"}, 128'(out_valid), 128'(1));
            chk({tag, "_hold_data"}, out_data, exp);
            chk({tag, "_hold_in_ready"}, 128'(in_ready), 128'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1 chk({tag, "_in_ready_handshake"}, 128'(in_ready), 128'(1));
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_clear"}, 128'(out_valid), 128'(0));
        chk({tag, "_idle"}, 128'(busy), 128'(0));
    endtask

    task automatic wait_rnd(input int target, input string tag);
        logic hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            @(negedge clk);
            if (rk_idx == 4'(target)) hit = 1'b1;
        end
        chk({tag, "_reach_rnd"}, 128'(hit), 128'(1));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] pa, pb, ca, cb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        rk_valid  = 1'b1;
        out_ready = 1'b0;
        junk      = '0;
        build_sbox();
        expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);

        #3;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_rk_idx", 128'(rk_idx), 128'(0));
        chk("rst_out_data", out_data, 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rk_valid = 1'b0;
        #1 chk("idle_in_ready_rkv0", 128'(in_ready), 128'(0));
        rk_valid = 1'b1;
        #1 chk("idle_in_ready_rkv1", 128'(in_ready), 128'(1));
        @(negedge clk);

        // FIPS-197 C.3
        accept(128'h00112233445566778899aabbccddeeff, "fips");
        run_to_done(128'h8ea2b7ca516745bfeafc49904b496089, 0, 0, "fips");
        drain(128'h8ea2b7ca516745bfeafc49904b496089, 0, "fips");

        // Stall 3 cycles at round 5, then hold the result 10 cycles.
        accept(128'h00112233445566778899aabbccddeeff, "stall");
        run_to_done(128'h8ea2b7ca516745bfeafc49904b496089, 5, 3, "stall");
        drain(128'h8ea2b7ca516745bfeafc49904b496089, 10, "stall");

        // Back-to-back under a random key.
        expand_key({rnd128(), rnd128()});
        pa = rnd128();
        pb = rnd128();
        ca = model_enc(pa);
        cb = model_enc(pb);
        accept(pa, "b2b_a");
        run_to_done(ca, 0, 0, "b2b_a");
        out_ready = 1'b1;
        accept(pb, "b2b_b");
        run_to_done(cb, 0, 0, "b2b_b");
        drain(cb, 2, "b2b_b");

        // Reset in the middle of round 7.
        pa = rnd128();
        accept(pa, "rstmid");
        wait_rnd(7, "rstmid");
        #2 rst = 1'b1;
        #1;
        chk("rstmid_out_valid", 128'(out_valid), 128'(0));
        chk("rstmid_busy", 128'(busy), 128'(0));
        chk("rstmid_rk_idx", 128'(rk_idx), 128'(0));
        chk("rstmid_out_data", out_data, 128'(0));
        @(negedge clk);
        rst = 1'b0;
        pa = rnd128();
        accept(pa, "after_rst");
        run_to_done(model_enc(pa), 0, 0, "after_rst");
        drain(model_enc(pa), 1, "after_rst");

`ifdef AES_ROUND_SEQ_ABORT_EN
        pa = rnd128();
        accept(pa, "abort");
        wait_rnd(3, "abort");
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_out_valid", 128'(out_valid), 128'(0));
        chk("abort_out_data", out_data, 128'(0));
        pa = rnd128();
        accept(pa, "after_abort");
        run_to_done(model_enc(pa), 0, 0, "after_abort");
        drain(model_enc(pa), 0, "after_abort");
`endif

        // Random blocks with random stall placement.
        for (int n = 0; n < 3; n++) begin
            int sr, sl;
            pa = rnd128();
            sr = int'($urandom_range(1, NR));
            sl = int'($urandom_range(0, 2));
            accept(pa, "rand");
            run_to_done(model_enc(pa), sr, sl, "rand");
            drain(model_enc(pa), int'($urandom_range(0, 3)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
